// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style pipeline: default widths, the
// layout of the 9-bit decode control word and the ALUOp encodings.
package mips_pkg;

    // Default datapath and register-address widths.
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    // Decode control word: {RegWr, MemRd, MemWr, MemToReg, ALUSrc, ALUOp[3:0]}.
    localparam int CTRL_W        = 9;
    localparam int CTRL_REGWR    = 8;
    localparam int CTRL_MEMRD    = 7;
    localparam int CTRL_MEMWR    = 6;
    localparam int CTRL_MEMTOREG = 5;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_ALUOP_HI = 3;
    localparam int CTRL_ALUOP_LO = 0;

    // ALUOp encodings carried in ctrl[3:0].
    localparam logic [3:0] ALUOP_ADD = 4'h0;
    localparam logic [3:0] ALUOP_SUB = 4'h1;
    localparam logic [3:0] ALUOP_AND = 4'h2;
    localparam logic [3:0] ALUOP_OR  = 4'h3;
    localparam logic [3:0] ALUOP_XOR = 4'h4;
    localparam logic [3:0] ALUOP_NOR = 4'h5;
    localparam logic [3:0] ALUOP_SLT = 4'h6;
    localparam logic [3:0] ALUOP_SLL = 4'h7;
    localparam logic [3:0] ALUOP_SRL = 4'h8;
    localparam logic [3:0] ALUOP_SRA = 4'h9;
    localparam logic [3:0] ALUOP_LUI = 4'hA;

    // Structured view of the control word; field order matches the bit layout.
    typedef struct packed {
        logic       reg_wr;
        logic       mem_rd;
        logic       mem_wr;
        logic       mem_to_reg;
        logic       alu_src;
        logic [3:0] alu_op;
    } ctrl_t;

    // True when the instruction reads its RB operand: register-register ALU
    // ops (ALUSrc=0) and stores (the store data comes from RB).
    function automatic logic uses_rb(input ctrl_t c);
        return (~c.alu_src) | c.mem_wr;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector. Purely combinational: asks PC and IF/ID to hold
// and EX to take a bubble when the instruction in decode needs the result of
// a load that is currently in EX.
module hazard_detect
    import mips_pkg::*;
#(
    parameter int REG_AW = mips_pkg::REG_AW
) (
    input  logic              rst,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_ra,
    input  logic [REG_AW-1:0] id_rb,
    input  logic              id_uses_rb,
    input  logic              ex_valid,
    input  logic              ex_mem_rd,
    input  logic [REG_AW-1:0] ex_rw,
    output logic              stall
);

    logic ex_is_load;
    logic match_a;
    logic match_b;

    // Compare the load destination against both decode sources; register 0
    // never carries a dependency.
    always_comb begin
        ex_is_load = ex_valid & ex_mem_rd & (ex_rw != '0);
        match_a    = (ex_rw == id_ra);
        match_b    = id_uses_rb & (ex_rw == id_rb);
        stall      = ~rst & ~flush & id_valid & ex_is_load & (match_a | match_b);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass into the operand buses and
// load-use stall generation.
//
// Flow semantics: id_valid marks a real instruction in the decode slot and
// ex_valid marks a real instruction in EX. There is no ready signal; the only
// backpressure is Stall, which holds PC and IF/ID for one cycle while this
// stage loads a bubble, so the same decode instruction is presented again on
// the following cycle. Flush squashes the decode slot into a bubble.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_BusA,
    input  logic [DATA_W-1:0] id_BusB,
    input  logic [REG_AW-1:0] id_RA,
    input  logic [REG_AW-1:0] id_RB,
    input  logic [REG_AW-1:0] id_RW,
    input  logic [DATA_W-1:0] id_Imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_RegWr,
    input  logic [REG_AW-1:0] wb_RW,
    input  logic [DATA_W-1:0] wb_BusW,
    input  logic              Flush,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_BusA,
    output logic [DATA_W-1:0] ex_BusB,
    output logic [REG_AW-1:0] ex_RA,
    output logic [REG_AW-1:0] ex_RB,
    output logic [REG_AW-1:0] ex_RW,
    output logic [DATA_W-1:0] ex_Imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              Stall
);

    ctrl_t             id_c;
    ctrl_t             ex_c;
    logic              wb_live;
    logic              byp_a;
    logic              byp_b;
    logic [DATA_W-1:0] bus_a_next;
    logic [DATA_W-1:0] bus_b_next;

    assign id_c = ctrl_t'(id_ctrl);
    assign ex_c = ctrl_t'(ex_ctrl);

    // Write-back bypass: the register file is written this same cycle, so its
    // read data is stale for a matching source; take BusW instead. Register 0
    // is hard-wired and never bypassed.
    always_comb begin
        wb_live    = wb_RegWr & (wb_RW != '0);
        byp_a      = wb_live & (wb_RW == id_RA);
        byp_b      = wb_live & (wb_RW == id_RB);
        bus_a_next = byp_a ? wb_BusW : id_BusA;
        bus_b_next = byp_b ? wb_BusW : id_BusB;
    end

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .rst        (Rst),
        .flush      (Flush),
        .id_valid   (id_valid),
        .id_ra      (id_RA),
        .id_rb      (id_RB),
        .id_uses_rb (uses_rb(id_c)),
        .ex_valid   (ex_valid),
        .ex_mem_rd  (ex_c.mem_rd),
        .ex_rw      (ex_RW),
        .stall      (Stall)
    );

    // Pipeline register: reset, flush and stall all load a bubble (every
    // field zero); otherwise copy the decode slot with bypassed operands.
    always_ff @(posedge Clk) begin
        if (Rst || Flush || Stall) begin
            ex_valid <= 1'b0;
            ex_BusA  <= '0;
            ex_BusB  <= '0;
            ex_RA    <= '0;
            ex_RB    <= '0;
            ex_RW    <= '0;
            ex_Imm   <= '0;
            ex_ctrl  <= '0;
        end else begin
            ex_valid <= id_valid;
            ex_BusA  <= bus_a_next;
            ex_BusB  <= bus_b_next;
            ex_RA    <= id_RA;
            ex_RB    <= id_RB;
            ex_RW    <= id_RW;
            ex_Imm   <= id_Imm;
            ex_ctrl  <= id_ctrl;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, normal load, load-use stall,
// non-stall corner cases, write-back bypass, flush/reset precedence and a
// back-to-back stream.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    localparam logic [8:0] C_LOAD  = 9'h1B0; // RegWr MemRd MemToReg ALUSrc
    localparam logic [8:0] C_ADD   = 9'h100; // RegWr, register-register
    localparam logic [8:0] C_ADDI  = 9'h110; // RegWr ALUSrc
    localparam logic [8:0] C_STORE = 9'h050; // MemWr ALUSrc
    localparam logic [8:0] C_SUB   = 9'h101; // RegWr, ALUOp=SUB

    logic          Clk;
    logic          Rst;
    logic          id_valid;
    logic [DW-1:0] id_BusA, id_BusB, id_Imm;
    logic [AW-1:0] id_RA, id_RB, id_RW;
    logic [8:0]    id_ctrl;
    logic          wb_RegWr;
    logic [AW-1:0] wb_RW;
    logic [DW-1:0] wb_BusW;
    logic          Flush;
    logic          ex_valid;
    logic [DW-1:0] ex_BusA, ex_BusB, ex_Imm;
    logic [AW-1:0] ex_RA, ex_RB, ex_RW;
    logic [8:0]    ex_ctrl;
    logic          Stall;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .id_valid (id_valid),
        .id_BusA  (id_BusA),
        .id_BusB  (id_BusB),
        .id_RA    (id_RA),
        .id_RB    (id_RB),
        .id_RW    (id_RW),
        .id_Imm   (id_Imm),
        .id_ctrl  (id_ctrl),
        .wb_RegWr (wb_RegWr),
        .wb_RW    (wb_RW),
        .wb_BusW  (wb_BusW),
        .Flush    (Flush),
        .ex_valid (ex_valid),
        .ex_BusA  (ex_BusA),
        .ex_BusB  (ex_BusB),
        .ex_RA    (ex_RA),
        .ex_RB    (ex_RB),
        .ex_RW    (ex_RW),
        .ex_Imm   (ex_Imm),
        .ex_ctrl  (ex_ctrl),
        .Stall    (Stall)
    );

    // Clock and reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Driver tasks
    task automatic drive_id(input logic v, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                            input logic [AW-1:0] rw, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] imm, input logic [8:0] c);
        id_valid = v; id_RA = ra; id_RB = rb; id_RW = rw;
        id_BusA = a; id_BusB = b; id_Imm = imm; id_ctrl = c;
    endtask

    task automatic drive_wb(input logic we, input logic [AW-1:0] rw, input logic [DW-1:0] d);
        wb_RegWr = we; wb_RW = rw; wb_BusW = d;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Clears EX with a flushed edge so each scenario starts from a bubble.
    task automatic clear_ex();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1; Flush = 1'b1;
        drive_id(1'b1, 5'd8, 5'd9, 5'd10, 32'hAAAA_5555, 32'h1234_5678, 32'hFFFF_0001, 9'h1FF);
        drive_wb(1'b1, 5'd8, 32'hCAFE_F00D);
        tick();
        checks++;
        if ({ex_valid, ex_BusA, ex_BusB, ex_RA, ex_RB, ex_RW, ex_Imm, ex_ctrl} !== '0) begin
            errors++;
            $display("FAIL reset_ex: got valid=%b A=%h B=%h RA=%0d RB=%0d RW=%0d Imm=%h ctrl=%h exp all 0",
                     ex_valid, ex_BusA, ex_BusB, ex_RA, ex_RB, ex_RW, ex_Imm, ex_ctrl);
        end
        checks++;
        if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", Stall); end
        Flush = 1'b0;
    endtask

    // First edge after reset must be a normal load.
    task automatic test_normal_load();
        drive_wb(1'b0, 5'd0, 32'h0);
        drive_id(1'b1, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 32'h33, C_ADD);
        Rst = 1'b0;
        #1;
        checks++;
        if (Stall !== 1'b0) begin errors++; $display("FAIL normal_prestall: got %b exp 0", Stall); end
        tick();
        checks++;
        if ({ex_valid, ex_BusA, ex_BusB, ex_RA, ex_RB, ex_RW, ex_Imm, ex_ctrl} !==
            {1'b1, 32'h11, 32'h22, 5'd3, 5'd4, 5'd5, 32'h33, C_ADD}) begin
            errors++;
            $display("FAIL normal_load: got valid=%b A=%h B=%h RA=%0d RB=%0d RW=%0d Imm=%h ctrl=%h exp 1 11 22 3 4 5 33 100",
                     ex_valid, ex_BusA, ex_BusB, ex_RA, ex_RB, ex_RW, ex_Imm, ex_ctrl);
        end
    endtask

    task automatic test_load_use();
        clear_ex();
        drive_id(1'b1, 5'd1, 5'd2, 5'd8, 32'h100, 32'h0, 32'h4, C_LOAD);
        tick();
        checks++;
        if (ex_ctrl !== C_LOAD || ex_RW !== 5'd8) begin
            errors++; $display("FAIL lu_load_in_ex: got ctrl=%h RW=%0d exp 1b0 8", ex_ctrl, ex_RW);
        end
        drive_id(1'b1, 5'd8, 5'd2, 5'd10, 32'hA, 32'hB, 32'h0, C_ADD);
        #1;
        checks++;
        if (Stall !== 1'b1) begin errors++; $display("FAIL lu_stall_on: got %b exp 1", Stall); end
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 9'h0 || ex_BusA !== 32'h0 || ex_RW !== 5'd0) begin
            errors++;
            $display("FAIL lu_bubble: got valid=%b ctrl=%h A=%h RW=%0d exp 0 0 0 0", ex_valid, ex_ctrl, ex_BusA, ex_RW);
        end
        checks++;
        if (Stall !== 1'b0) begin errors++; $display("FAIL lu_stall_off: got %b exp 0", Stall); end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_RA !== 5'd8 || ex_RW !== 5'd10 || ex_BusA !== 32'hA || ex_ctrl !== C_ADD) begin
            errors++;
            $display("FAIL lu_add_enters: got valid=%b RA=%0d RW=%0d A=%h ctrl=%h exp 1 8 10 a 100",
                     ex_valid, ex_RA, ex_RW, ex_BusA, ex_ctrl);
        end
    endtask

    task automatic test_no_stall_cases();
        clear_ex();
        drive_id(1'b1, 5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 32'h0, C_LOAD);
        tick();
        drive_id(1'b1, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 32'h0, C_ADD);
        #1;
        checks++;
        if (Stall !== 1'b0) begin errors++; $display("FAIL ns_rw_zero: got %b exp 0", Stall); end

        clear_ex();
        drive_id(1'b1, 5'd1, 5'd2, 5'd9, 32'h0, 32'h0, 32'h0, C_LOAD);
        tick();
        drive_id(1'b1, 5'd1, 5'd9, 5'd3, 32'h0, 32'h0, 32'h0, C_ADDI);
        #1;
        checks++;
        if (Stall !== 1'b0) begin errors++; $display("FAIL ns_alusrc_rb: got %b exp 0", Stall); end
        drive_id(1'b1, 5'd1, 5'd9, 5'd0, 32'h0, 32'h0, 32'h0, C_STORE);
        #1;
        checks++;
        if (Stall !== 1'b1) begin errors++; $display("FAIL st_store_rb: got %b exp 1", Stall); end
        drive_id(1'b1, 5'd4, 5'd9, 5'd3, 32'h0, 32'h0, 32'h0, C_ADD);
        #1;
        checks++;
        if (Stall !== 1'b1) begin errors++; $display("FAIL st_rtype_rb: got %b exp 1", Stall); end
        drive_id(1'b0, 5'd9, 5'd9, 5'd3, 32'h0, 32'h0, 32'h0, C_ADD);
        #1;
        checks++;
        if (Stall !== 1'b0) begin errors++; $display("FAIL ns_id_invalid: got %b exp 0", Stall); end
    endtask

    task automatic test_bypass();
        clear_ex();
        drive_wb(1'b1, 5'd7, 32'hDEAD_BEEF);
        drive_id(1'b1, 5'd7, 5'd7, 5'd3, 32'h0, 32'h0, 32'h0, C_ADD);
        tick();
        checks++;
        if (ex_BusA !== 32'hDEAD_BEEF || ex_BusB !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL byp_both: got A=%h B=%h exp deadbeef deadbeef", ex_BusA, ex_BusB);
        end
        drive_wb(1'b1, 5'd0, 32'hDEAD_BEEF);
        drive_id(1'b1, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 32'h0, C_ADD);
        tick();
        checks++;
        if (ex_BusA !== 32'h0 || ex_BusB !== 32'h0) begin
            errors++; $display("FAIL byp_r0: got A=%h B=%h exp 0 0", ex_BusA, ex_BusB);
        end
        drive_id(1'b1, 5'd0, 5'd0, 5'd3, 32'h55, 32'h66, 32'h0, C_ADD);
        tick();
        checks++;
        if (ex_BusA !== 32'h55 || ex_BusB !== 32'h66) begin
            errors++; $display("FAIL byp_r0_pass: got A=%h B=%h exp 55 66", ex_BusA, ex_BusB);
        end
        drive_wb(1'b1, 5'd7, 32'h1357_9BDF);
        drive_id(1'b1, 5'd7, 5'd4, 5'd3, 32'h77, 32'h44, 32'h0, C_ADD);
        tick();
        checks++;
        if (ex_BusA !== 32'h1357_9BDF || ex_BusB !== 32'h44) begin
            errors++; $display("FAIL byp_a_only: got A=%h B=%h exp 13579bdf 44", ex_BusA, ex_BusB);
        end
        drive_id(1'b1, 5'd4, 5'd7, 5'd3, 32'h77, 32'h44, 32'h0, C_ADD);
        tick();
        checks++;
        if (ex_BusA !== 32'h77 || ex_BusB !== 32'h1357_9BDF) begin
            errors++; $display("FAIL byp_b_only: got A=%h B=%h exp 77 13579bdf", ex_BusA, ex_BusB);
        end
        drive_wb(1'b0, 5'd7, 32'h1357_9BDF);
        drive_id(1'b1, 5'd7, 5'd7, 5'd3, 32'h77, 32'h88, 32'h0, C_ADD);
        tick();
        checks++;
        if (ex_BusA !== 32'h77 || ex_BusB !== 32'h88) begin
            errors++; $display("FAIL byp_no_regwr: got A=%h B=%h exp 77 88", ex_BusA, ex_BusB);
        end
        drive_wb(1'b1, 5'd7, 32'h1357_9BDF);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        checks++;
        if (ex_BusA !== 32'h0 || ex_BusB !== 32'h0 || ex_valid !== 1'b0) begin
            errors++; $display("FAIL byp_flush: got A=%h B=%h valid=%b exp 0 0 0", ex_BusA, ex_BusB, ex_valid);
        end
        drive_wb(1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_flush_and_reset_on_stall();
        clear_ex();
        drive_id(1'b1, 5'd1, 5'd2, 5'd8, 32'h0, 32'h0, 32'h0, C_LOAD);
        tick();
        drive_id(1'b1, 5'd8, 5'd2, 5'd10, 32'hA, 32'hB, 32'h0, C_ADD);
        Flush = 1'b1;
        #1;
        checks++;
        if (Stall !== 1'b0) begin errors++; $display("FAIL fl_stall: got %b exp 0", Stall); end
        tick();
        Flush = 1'b0;
        checks++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 9'h0 || ex_RA !== 5'd0) begin
            errors++; $display("FAIL fl_bubble: got valid=%b ctrl=%h RA=%0d exp 0 0 0", ex_valid, ex_ctrl, ex_RA);
        end

        drive_id(1'b1, 5'd1, 5'd2, 5'd8, 32'h0, 32'h0, 32'h0, C_LOAD);
        tick();
        drive_id(1'b1, 5'd8, 5'd2, 5'd10, 32'hA, 32'hB, 32'h0, C_ADD);
        #1;
        checks++;
        if (Stall !== 1'b1) begin errors++; $display("FAIL rs_pre_stall: got %b exp 1", Stall); end
        Rst = 1'b1;
        #1;
        checks++;
        if (Stall !== 1'b0) begin errors++; $display("FAIL rs_stall: got %b exp 0", Stall); end
        tick();
        checks++;
        if ({ex_valid, ex_BusA, ex_BusB, ex_RA, ex_RB, ex_RW, ex_Imm, ex_ctrl} !== '0) begin
            errors++; $display("FAIL rs_ex_zero: got valid=%b RW=%0d ctrl=%h exp 0 0 0", ex_valid, ex_RW, ex_ctrl);
        end
        Rst = 1'b0;
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_RA !== 5'd8 || ex_RW !== 5'd10 || ex_BusB !== 32'hB) begin
            errors++;
            $display("FAIL rs_first_load: got valid=%b RA=%0d RW=%0d B=%h exp 1 8 10 b", ex_valid, ex_RA, ex_RW, ex_BusB);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0]    c_tab [3];
        logic [AW-1:0] rw_tab[3];
        logic [DW-1:0] a_tab [3];
        c_tab  = '{C_ADD, C_SUB, C_ADDI};
        rw_tab = '{5'd11, 5'd12, 5'd13};
        a_tab  = '{32'h1000, 32'h2000, 32'h3000};
        clear_ex();
        for (int i = 0; i < 3; i++) begin
            drive_id(1'b1, 5'd20 + 5'(i), 5'd21, rw_tab[i], a_tab[i], 32'h5, 32'(i), c_tab[i]);
            tick();
            checks++;
            if (ex_valid !== 1'b1 || ex_RW !== rw_tab[i] || ex_BusA !== a_tab[i] ||
                ex_ctrl !== c_tab[i] || ex_Imm !== 32'(i) || ex_RA !== 5'd20 + 5'(i)) begin
                errors++;
                $display("FAIL b2b_%0d: got valid=%b RW=%0d A=%h ctrl=%h Imm=%h RA=%0d exp 1 %0d %h %h %h %0d",
                         i, ex_valid, ex_RW, ex_BusA, ex_ctrl, ex_Imm, ex_RA,
                         rw_tab[i], a_tab[i], c_tab[i], 32'(i), 5'd20 + 5'(i));
            end
        end
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 9'h0);
        tick();
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b exp 0", ex_valid); end
    endtask

    initial begin
        Rst = 1'b1;
        Flush = 1'b0;
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 9'h0);
        drive_wb(1'b0, 5'd0, 32'h0);
        test_reset();
        test_normal_load();
        test_load_use();
        test_no_stall_cases();
        test_bypass();
        test_flush_and_reset_on_stall();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width of BusA/BusB/BusW/Imm.
REQ-002 SHALL have parameter REG_AW, default 5, register-address width of RA/RB/RW.
REQ-003 SHALL use one clock and a synchronous, active-high reset; no other clock or reset exists.
REQ-004 Clk  in  1  rising-edge clock.
REQ-005 Rst  in  1  synchronous active-high reset.
REQ-006 id_valid  in  1  decode slot holds a real instruction.
REQ-007 id_BusA, id_BusB  in  DATA_W  RegisterFile BusA/BusB read data.
REQ-008 id_RA, id_RB, id_RW  in  REG_AW  source and destination register numbers.
REQ-009 id_Imm  in  DATA_W  sign-extended immediate.
REQ-010 id_ctrl  in  9  {RegWr, MemRd, MemWr, MemToReg, ALUSrc, ALUOp[3:0]}.
REQ-011 wb_RegWr, wb_RW, wb_BusW  in  1/REG_AW/DATA_W  write-back port driving RegisterFile RegWr/RW/BusW this cycle.
REQ-012 Flush  in  1  squash decode-slot instruction (taken branch/jump).
REQ-013 ex_valid, ex_BusA, ex_BusB, ex_RA, ex_RB, ex_RW, ex_Imm, ex_ctrl  out  as inputs  registered EX-stage copies.
REQ-014 Stall  out  1  combinational load-use stall request to PC and IF/ID.

Function
REQ-015 SHALL register all ex_* outputs on rising Clk; latency ID->EX exactly one cycle.
REQ-016 Update priority per edge SHALL be: Rst, then Flush, then Stall, then normal load.
REQ-017 Bubble SHALL mean ex_valid=0, ex_ctrl=0, all other ex_* = 0.
REQ-018 Flush=1 SHALL load a bubble regardless of Stall.
REQ-019 Stall=1 (Flush=0) SHALL load a bubble; IF/ID holds, so the same ID instruction re-presents next cycle.
REQ-020 Normal load SHALL copy every id_* field to its ex_* counterpart, id_valid to ex_valid.
REQ-021 Stall SHALL = ~Rst & ~Flush & id_valid & ex_valid & ex_ctrl.MemRd & (ex_RW!=0) & ((ex_RW==id_RA) | (usesB & ex_RW==id_RB)).
REQ-022 usesB SHALL = ~id_ctrl.ALUSrc | id_ctrl.MemWr.
REQ-023 Stall SHALL last exactly one cycle per load-use pair (bubble clears ex_valid).
REQ-024 Write-back bypass: if wb_RegWr & wb_RW!=0 & wb_RW==id_RA, ex_BusA SHALL load wb_BusW instead of id_BusA; same rule for RB/ex_BusB.
REQ-025 Bypass SHALL never apply for register 0; id_RA=0 always passes id_BusA unchanged.
REQ-026 wb_RW==id_RA==id_RB SHALL bypass both operands in the same cycle.
REQ-027 Bypass SHALL be ignored on Flush, Stall or Rst cycles.

Reset
REQ-028 Rst=1 at an edge SHALL clear all ex_* outputs to 0 (bubble), overriding Flush and Stall.
REQ-029 Stall SHALL read 0 while Rst=1; reset mid-stall SHALL drop the pending stall.
REQ-030 First edge after Rst deasserts SHALL perform a normal load.

Structure
REQ-031 Shared package mips_pkg SHALL hold DATA_W, REG_AW, the id_ctrl bit positions and ALUOp encodings.
REQ-032 Load-use comparison SHALL be a sub-module hazard_detect (pure combinational, outputs Stall); pipeline register and bypass muxes stay in id_ex_stage.

Verification
REQ-033 Rst=1 with all inputs nonzero, one edge -> all ex_* = 0, Stall=0.
REQ-034 id RA=3,RB=4,BusA=0x11,BusB=0x22,RW=5,valid=1, no wb -> next cycle ex_BusA=0x11, ex_BusB=0x22, ex_RW=5, ex_valid=1.
REQ-035 EX holds load ex_RW=8; ID add RA=8 -> Stall=1 one cycle, bubble loaded, add enters EX next edge, Stall=0.
REQ-036 EX load ex_RW=0, ID RA=0 -> Stall=0; ALUSrc=1,MemWr=0, ex_RW==id_RB=9 -> Stall=0.
REQ-037 wb_RegWr=1, wb_RW=7, wb_BusW=0xDEADBEEF, id RA=RB=7, id_BusA=id_BusB=0 -> ex_BusA=ex_BusB=0xDEADBEEF; same with wb_RW=0 -> both 0.
REQ-038 Flush=1 while Stall condition true -> Stall=0, bubble loaded; Rst asserted on a stall cycle -> ex_* = 0, Stall=0.
